// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master (I/D L2) line arbiter onto one slow-memory port; define ARB_RR_EN for round-robin, else fixed D priority
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DONE_I, DONE_D} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic              i_req, d_req, pick_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;
`ifdef ARB_RR_EN
    assign pick_d = d_req & (~i_req | ~last_grant_q);
`else
    assign pick_d = d_req;
`endif

    // next-state: latch winner in IDLE, hold memory request until mem_ready, one-cycle ready pulse
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        case (state_q)
            IDLE: if (i_req | d_req) begin
                state_d      = pick_d ? GNT_D : GNT_I;
                last_grant_d = pick_d;
                mem_write_d  = pick_d ? d_write : i_write;
                mem_read_d   = pick_d ? (d_read & ~d_write) : (i_read & ~i_write);
                mem_addr_d   = pick_d ? d_addr : i_addr;
                mem_wdata_d  = pick_d ? d_wdata : i_wdata;
            end
            GNT_I: if (mem_ready) begin
                state_d     = DONE_I;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                i_ready_d   = 1'b1;
                i_rdata_d   = mem_read_q ? mem_rdata : i_rdata_q;
            end
            GNT_D: if (mem_ready) begin
                state_d     = DONE_D;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                d_ready_d   = 1'b1;
                d_rdata_d   = mem_read_q ? mem_rdata : d_rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; reset aborts any transaction immediately
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic         clk = 1'b0;
    logic         proc_reset;
    logic         i_read, i_write, d_read, d_write;
    logic [27:0]  i_addr, d_addr, mem_addr;
    logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic         i_ready, d_ready, mem_read, mem_write, mem_ready;
    int           n_chk = 0;
    int           n_fail = 0;

    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] C3 = {16{8'hC3}};
    localparam logic [127:0] WD = 128'h0123456789ABCDEF0123456789ABCDEF;

    mem_port_arbiter dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // memory answers lat cycles after the request became visible
    task automatic mem_resp(input int lat, input logic [127:0] data);
        for (int k = 1; k < lat; k++) step();
        mem_ready = 1'b1;
        mem_rdata = data;
        step();
        mem_ready = 1'b0;
    endtask

    initial begin
        proc_reset = 1'b1;
        {i_read, i_write, d_read, d_write, mem_ready} = '0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
        step(); step();
        proc_reset = 1'b0;
        check("rst_mem_rw", {mem_read, mem_write}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ready", {i_ready, d_ready}, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);

        // I read, memory answers after 6 cycles
        i_read = 1'b1; i_addr = 28'h0000010;
        step();
        check("t1_req", {mem_read, mem_write}, 2'b10);
        check("t1_addr", mem_addr, 28'h0000010);
        for (int k = 1; k < 6; k++) begin
            step();
            check("t1_hold", {mem_read, mem_write, mem_addr, i_ready, d_ready}, {2'b10, 28'h0000010, 2'b00});
        end
        mem_ready = 1'b1; mem_rdata = A5;
        step();
        mem_ready = 1'b0; i_read = 1'b0;
        check("t1_ready", {i_ready, d_ready, mem_read}, 3'b100);
        check("t1_rdata", i_rdata, A5);
        step();
        check("t1_pulse", {i_ready, d_ready}, 0);

        // D write at top address: rdata must not be captured
        d_write = 1'b1; d_addr = 28'hFFFFFFF; d_wdata = WD;
        step();
        check("t2_req", {mem_read, mem_write}, 2'b01);
        check("t2_addr", mem_addr, 28'hFFFFFFF);
        check("t2_wdata", mem_wdata, WD);
        mem_resp(3, 128'hDEAD);
        d_write = 1'b0;
        check("t2_ready", {i_ready, d_ready, mem_write}, 3'b010);
        check("t2_rdata", d_rdata, 0);
        step();
        check("t2_pulse", d_ready, 0);

        // read+write together is a write; i_rdata keeps the earlier line
        i_read = 1'b1; i_write = 1'b1; i_addr = 28'h0000020; i_wdata = C3;
        step();
        check("rw_op", {mem_read, mem_write}, 2'b01);
        check("rw_wdata", mem_wdata, C3);
        mem_resp(1, 128'hBEEF);
        {i_read, i_write} = 2'b00;
        check("rw_ready", i_ready, 1);
        check("rw_rdata", i_rdata, A5);
        step();

        i_addr = 28'h100; d_addr = 28'h200;
`ifdef ARB_RR_EN
        // round-robin: D wins first tie, then I, then D again
        i_read = 1'b1; d_read = 1'b1;
        step();
        check("rr_g1", mem_addr, 28'h200);
        mem_resp(2, 128'h11);
        d_read = 1'b0;
        check("rr_r1", {i_ready, d_ready}, 2'b01);
        step();
        step();
        check("rr_g2", {mem_read, mem_addr}, {1'b1, 28'h100});
        mem_resp(2, 128'h22);
        i_read = 1'b0;
        check("rr_r2", {i_ready, d_ready}, 2'b10);
        check("rr_d2", i_rdata, 128'h22);
        step();
        i_read = 1'b1; d_read = 1'b1;
        step();
        check("rr_g3", mem_addr, 28'h200);
        mem_resp(2, 128'h33);
        i_read = 1'b0; d_read = 1'b0;
        check("rr_r3", {i_ready, d_ready}, 2'b01);
        step();
`else
        // fixed priority: D wins while it keeps requesting
        i_read = 1'b1; d_read = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            check("fx_grant_d", {mem_read, mem_addr}, {1'b1, 28'h200});
            mem_resp(2, 128'(k + 1));
            if (k == 2) d_read = 1'b0;
            check("fx_ready_d", {i_ready, d_ready}, 2'b01);
            check("fx_rdata_d", d_rdata, 128'(k + 1));
            step();
            check("fx_idle", {mem_read, d_ready}, 0);
            step();
        end
        check("fx_grant_i", {mem_read, mem_addr}, {1'b1, 28'h100});
        mem_resp(2, 128'h44);
        i_read = 1'b0;
        check("fx_ready_i", {i_ready, d_ready}, 2'b10);
        check("fx_rdata_i", i_rdata, 128'h44);
        step();
`endif

        // reset in the middle of a D read
        d_read = 1'b1; d_addr = 28'h333;
        step();
        check("t5_req", mem_read, 1);
        step();
        proc_reset = 1'b1;
        step();
        proc_reset = 1'b0; d_read = 1'b0;
        check("t5_clr", {mem_read, mem_write, mem_addr, i_ready, d_ready}, 0);
        check("t5_rdata", i_rdata | d_rdata, 0);
        mem_ready = 1'b1; mem_rdata = 128'h99;
        step();
        mem_ready = 1'b0;
        step();
        check("t5_ignored", {i_ready, d_ready, mem_read}, 0);
        check("t5_nocap", d_rdata, 0);
        i_read = 1'b1; i_addr = 28'h44;
        step();
        check("t5_fresh", {mem_read, mem_addr}, {1'b1, 28'h44});
        mem_resp(1, 128'h77);
        i_read = 1'b0;
        check("t5_fresh_rdy", {i_ready, i_rdata}, {1'b1, 128'h77});
        step();

        // mem_ready stuck high while idle
        mem_ready = 1'b1; mem_rdata = C3;
        step(); step();
        check("t6_idle", {i_ready, d_ready, mem_read}, 0);
        d_read = 1'b1; d_addr = 28'h55;
        step();
        check("t6_grant", {mem_read, d_ready}, 2'b10);
        step();
        mem_ready = 1'b0; d_read = 1'b0;
        check("t6_ready", {d_ready, mem_read}, 2'b10);
        check("t6_rdata", d_rdata, C3);
        step();
        check("t6_pulse", d_ready, 0);
        step();
        check("t6_back_idle", {mem_read, mem_write, d_ready}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
